// File: rtl/spio_hss_multiplexer_pkt_store_gbn_pkg.sv
// Shared defaults and return-path action codes for the go-back-N packet store.
// The retransmit timeout is enabled by defining SPIO_PKT_STORE_TIMEOUT_EN.
package spio_hss_multiplexer_pkt_store_gbn_pkg;

    localparam int PKT_BITS_DEF = 72;
    localparam int BUF_BITS_DEF = 3;
    localparam int SEQ_BITS_DEF = 7;
    localparam int PLD_BIT_DEF  = 1;
    localparam int TO_BITS_DEF  = 10;

    // One decision per cycle on the return path; NAK outranks ACK, ACK outranks timeout.
    typedef enum logic [2:0] {
        RET_HOLD,
        RET_ACK_ALL,
        RET_ACK_PTR,
        RET_NAK,
        RET_REJECT,
        RET_TIMEOUT
    } retAction_t;

endpackage

// File: rtl/spio_hss_multiplexer_pkt_store_gbn_if.sv
// Packet input, frame issue and ACK/NAK return signals of the go-back-N packet store.
// slave = the store's view, master = the surrounding logic's view.
interface spio_hss_multiplexer_pkt_store_gbn_if
    import spio_hss_multiplexer_pkt_store_gbn_pkg::*;
#(
    parameter int PKT_BITS = PKT_BITS_DEF,
    parameter int SEQ_BITS = SEQ_BITS_DEF,
    parameter int BUF_BITS = BUF_BITS_DEF
);
    logic                cfc_rem;
    logic                vld_ack;
    logic                vld_nak;
    logic [SEQ_BITS-1:0] ack_seq;
    logic [PKT_BITS-1:0] pkt_data;
    logic                pkt_vld;
    logic                pkt_rdy;
    logic [SEQ_BITS-1:0] bpkt_seq;
    logic                bpkt_rq;
    logic                bpkt_gt;
    logic [PKT_BITS-1:0] bpkt_data;
    logic                bpkt_pld;
    logic                bpkt_pres;
    logic                empty;
    logic                full;
    logic [BUF_BITS-1:0] occupancy;
    logic                ack_err;
    logic                to_rtx;

    modport slave (
        input  cfc_rem, vld_ack, vld_nak, ack_seq, pkt_data, pkt_vld, bpkt_seq, bpkt_rq,
        output pkt_rdy, bpkt_gt, bpkt_data, bpkt_pld, bpkt_pres, empty, full, occupancy,
               ack_err, to_rtx
    );

    modport master (
        output cfc_rem, vld_ack, vld_nak, ack_seq, pkt_data, pkt_vld, bpkt_seq, bpkt_rq,
        input  pkt_rdy, bpkt_gt, bpkt_data, bpkt_pld, bpkt_pres, empty, full, occupancy,
               ack_err, to_rtx
    );

endinterface

// File: rtl/spio_hss_multiplexer_window_chk.sv
// Modulo window test: is x within [lo, hi] when pointers wrap at 2^BUF_BITS?
module spio_hss_multiplexer_window_chk
    import spio_hss_multiplexer_pkt_store_gbn_pkg::*;
#(
    parameter int BUF_BITS = BUF_BITS_DEF
) (
    input  logic [BUF_BITS-1:0] i_lo,
    input  logic [BUF_BITS-1:0] i_hi,
    input  logic [BUF_BITS-1:0] i_x,
    output logic                o_inWin
);
    logic [BUF_BITS-1:0] w_xOff;
    logic [BUF_BITS-1:0] w_span;

    // Rebasing both ends on lo turns the wrapped compare into a plain unsigned one.
    assign w_xOff  = i_x - i_lo;
    assign w_span  = i_hi - i_lo;
    assign o_inWin = (w_xOff <= w_span);

endmodule

// File: rtl/spio_hss_multiplexer_pkt_store_gbn.sv
// Go-back-N packet store: holds packets until ACKed, rewinds on NAK, reports occupancy.
// Optional retransmit timeout compiled in with SPIO_PKT_STORE_TIMEOUT_EN.
module spio_hss_multiplexer_pkt_store_gbn
    import spio_hss_multiplexer_pkt_store_gbn_pkg::*;
#(
    parameter int PKT_BITS = PKT_BITS_DEF,
    parameter int BUF_BITS = BUF_BITS_DEF,
    parameter int SEQ_BITS = SEQ_BITS_DEF,
    parameter int PLD_BIT  = PLD_BIT_DEF,
    parameter int TO_BITS  = TO_BITS_DEF
) (
    input logic clk,
    input logic rst,
    spio_hss_multiplexer_pkt_store_gbn_if.slave sif
);
    localparam int DEPTH = 1 << BUF_BITS;
    typedef logic [BUF_BITS-1:0] ptr_t;

    logic [PKT_BITS-1:0] r_buf [DEPTH];
    ptr_t                r_seqMap [DEPTH];
    ptr_t                r_ba, r_br, r_bw;
    logic                r_empty, r_full, r_pktRdy;
    logic                r_bpktGt, r_bpktPld, r_bpktPres;
    logic [PKT_BITS-1:0] r_bpktData;
    logic                r_ackErr, r_toRtx;

    logic [SEQ_BITS-1:0] w_ackSeq;
    logic                w_writing, w_reading, w_pInWin, w_toFire, w_nxtFull;
    ptr_t                w_ackPtr, w_nxtBa, w_nxtBr, w_nxtBw, w_nxtBwInc;
    retAction_t          w_retAct;

    assign w_ackSeq  = sif.ack_seq;
    assign w_writing = sif.pkt_vld & ~r_full;
    assign w_reading = sif.bpkt_rq & ~r_empty & sif.cfc_rem;
    assign w_ackPtr  = r_seqMap[w_ackSeq[BUF_BITS-1:0]];

    spio_hss_multiplexer_window_chk #(.BUF_BITS(BUF_BITS)) u_winChk (
        .i_lo    (r_ba),
        .i_hi    (r_br),
        .i_x     (w_ackPtr),
        .o_inWin (w_pInWin)
    );

`ifdef SPIO_PKT_STORE_TIMEOUT_EN
    logic [TO_BITS-1:0] r_toCnt;

    assign w_toFire = &r_toCnt;

    // Idle time with unacknowledged frames outstanding; any ACK/NAK restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_toCnt <= '0;
        end else if (sif.vld_ack || sif.vld_nak || (r_ba == r_br) || w_toFire) begin
            r_toCnt <= '0;
        end else begin
            r_toCnt <= r_toCnt + 1'b1;
        end
    end
`else
    assign w_toFire = 1'b0 & (TO_BITS > 0);
`endif

    always_comb begin
        w_retAct = RET_HOLD;
        if (sif.vld_nak) begin
            w_retAct = w_pInWin ? RET_NAK : RET_REJECT;
        end else if (sif.vld_ack) begin
            if (w_ackSeq == sif.bpkt_seq) begin
                w_retAct = RET_ACK_ALL;
            end else begin
                w_retAct = w_pInWin ? RET_ACK_PTR : RET_REJECT;
            end
        end else if (w_toFire) begin
            w_retAct = RET_TIMEOUT;
        end
    end

    // A rewind overrides the read increment of br; the grant itself still goes out.
    always_comb begin
        w_nxtBa = r_ba;
        w_nxtBr = r_br + ptr_t'(w_reading);
        case (w_retAct)
            RET_ACK_ALL: w_nxtBa = r_br;
            RET_ACK_PTR: w_nxtBa = w_ackPtr;
            RET_NAK: begin
                w_nxtBa = w_ackPtr;
                w_nxtBr = w_ackPtr;
            end
            RET_TIMEOUT: w_nxtBr = r_ba;
            default: ;
        endcase
    end

    assign w_nxtBw    = r_bw + ptr_t'(w_writing);
    assign w_nxtBwInc = w_nxtBw + ptr_t'(1);
    assign w_nxtFull  = (w_nxtBwInc == w_nxtBa);

    // Storage needs no reset: stale slots are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_writing) begin
            r_buf[r_bw] <= sif.pkt_data;
        end
        if (sif.bpkt_rq) begin
            r_seqMap[sif.bpkt_seq[BUF_BITS-1:0]] <= r_br;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ba        <= '0;
            r_br        <= '0;
            r_bw        <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_pktRdy    <= 1'b0;
            r_bpktGt    <= 1'b0;
            r_bpktData  <= '0;
            r_bpktPld   <= 1'b0;
            r_bpktPres  <= 1'b0;
            r_ackErr    <= 1'b0;
            r_toRtx     <= 1'b0;
        end else begin
            r_ba        <= w_nxtBa;
            r_br        <= w_nxtBr;
            r_bw        <= w_nxtBw;
            r_empty     <= (w_nxtBr == w_nxtBw);
            r_full      <= w_nxtFull;
            r_pktRdy    <= ~w_nxtFull;
            r_bpktGt    <= w_reading;
            if (w_reading) begin
                r_bpktData <= r_buf[r_br];
                r_bpktPld  <= r_buf[r_br][PLD_BIT];
            end
            if (sif.bpkt_rq) begin
                r_bpktPres <= w_reading;
            end
            r_ackErr    <= (w_retAct == RET_REJECT);
            r_toRtx     <= (w_retAct == RET_TIMEOUT);
        end
    end

    assign sif.pkt_rdy   = r_pktRdy;
    assign sif.bpkt_gt   = r_bpktGt;
    assign sif.bpkt_data = r_bpktData;
    assign sif.bpkt_pld  = r_bpktPld;
    assign sif.bpkt_pres = r_bpktPres;
    assign sif.empty     = r_empty;
    assign sif.full      = r_full;
    assign sif.occupancy = r_bw - r_ba;
    assign sif.ack_err   = r_ackErr;
    assign sif.to_rtx    = r_toRtx;

endmodule
